tt_alu_host: RTL and testbench

TT_ALU_HOST -- requirements
Module: tt_alu_host

---
 rtl/tt_alu_pkg.sv | 25 ++
 rtl/tt_alu_core.sv | 55 +++++
 rtl/tt_alu_host.sv | 90 +++++++++
 tb/tb_tt_alu_host.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/tt_alu_pkg.sv
// Shared opcode, FSM state and data-width definitions for the tt_alu_host slice.
// Latency: none (package only).
// Backpressure: none (package only).
package tt_alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_RSUB = 3'b010,
        OP_MUL  = 3'b011,
        OP_AND  = 3'b100,
        OP_DIV  = 3'b101,
        OP_RDIV = 3'b110,
        OP_OR   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tt_alu_core.sv
// Combinational 8-bit ALU datapath; the divider exists only with TT_ALU_HOST_DIV_EN.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the result follows the inputs.
module tt_alu_core
    import tt_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_t               op,
    output logic [DATA_W-1:0] y,
    output logic              err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_RSUB: y = b - a;
            OP_MUL:  y = a * b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
`ifdef TT_ALU_HOST_DIV_EN
            OP_DIV: begin
                if (b == '0) begin
                    y   = '1;
                    err = 1'b1;
                end else begin
                    y = a / b;
                end
            end
            OP_RDIV: begin
                if (a == '0) begin
                    y   = '1;
                    err = 1'b1;
                end else begin
                    y = b / a;
                end
            end
`else
            // No divider built: division opcodes still complete, flagged as errors.
            OP_DIV, OP_RDIV: begin
                y   = '0;
                err = 1'b1;
            end
`endif
            default: begin
                y   = '0;
                err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/tt_alu_host.sv
// Pin-level host for tt_alu_core: accepts one command in IDLE, executes, pulses done (TT_ALU_HOST_DIV_EN enables divide).
// Latency: accept edge k, result/err at edge k+1, done high for cycle k+2, back to IDLE at edge k+2.
// Backpressure: cmd_valid is ignored while busy; a held cmd_valid re-issues every 3 cycles.
module tt_alu_host
    import tt_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t              state;
    op_t                 op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   acc;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   core_y;
    logic                core_err;

    logic cmd_vld;
    logic chain;
    assign cmd_vld = uio_in[3];
    assign chain   = uio_in[4];

    wire unused_ok = &{1'b0, ena, uio_in[7:5]};

    tt_alu_core u_core (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .y   (core_y),
        .err (core_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_vld) begin
                        op_q   <= op_t'(uio_in[2:0]);
                        b_q    <= {4'b0, ui_in[7:4]};
                        a_q    <= chain ? acc : {4'b0, ui_in[3:0]};
                        busy_q <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc    <= core_y;
                    err_q  <= core_err;
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // The accumulator is the result register, so acc and uo_out can never diverge.
    assign uo_out  = acc;
    assign uio_out = {err_q, done_q, busy_q, 5'b0};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_alu_host.sv
// Directed-vector bench for tt_alu_host; expected values are hand-computed constants.
// Build with or without TT_ALU_HOST_DIV_EN to match the DUT configuration.
module tb_tt_alu_host;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec;
    int n_bad;

    tt_alu_host dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the following IDLE cycle.
    task automatic issue(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic chain,
                         input logic [7:0] exp_y, input logic exp_err);
        ui_in  = {b, a};
        uio_in = {3'b000, chain, 1'b1, op};
        @(negedge clk);
        uio_in[3] = 1'b0;
        chk_vec({tag, "_exec_busy"}, uio_out & 8'h60, 8'h20);
        @(negedge clk);
        chk_vec({tag, "_done_y"}, uo_out, exp_y);
        chk_vec({tag, "_done_flags"}, uio_out, {exp_err, 2'b11, 5'b0});
        @(negedge clk);
        chk_vec({tag, "_idle_flags"}, uio_out, {exp_err, 2'b00, 5'b0});
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        ena    = 1'b1;
        rst_n  = 1'b0;
        ui_in  = 8'h53;
        uio_in = 8'h08;
        #1;
        chk_vec("rst_uo_out", uo_out, 8'h00);
        chk_vec("rst_uio_out", uio_out, 8'h00);
        chk_vec("rst_uio_oe", uio_oe, 8'hE0);

        // cmd_valid already high while in reset: acceptance only at a clean edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_vec("post_rst_not_busy", uio_out, 8'h00);
        @(negedge clk);
        chk_vec("post_rst_busy", uio_out & 8'h60, 8'h20);
        uio_in = 8'h00;
        repeat (2) @(negedge clk);

        issue("add_3_5",  4'd3, 4'd5, 3'b000, 1'b0, 8'h08, 1'b0);
        issue("sub_2_5",  4'd2, 4'd5, 3'b001, 1'b0, 8'hFD, 1'b0);
        issue("chain_mul3", 4'd0, 4'd3, 3'b011, 1'b1, 8'hF7, 1'b0);
        issue("rsub_7_2", 4'd7, 4'd2, 3'b010, 1'b0, 8'hFB, 1'b0);
        issue("and_c_a",  4'hC, 4'hA, 3'b100, 1'b0, 8'h08, 1'b0);
        issue("or_c_3",   4'hC, 4'h3, 3'b111, 1'b0, 8'h0F, 1'b0);

`ifdef TT_ALU_HOST_DIV_EN
        issue("div_7_0",  4'd7, 4'd0, 3'b101, 1'b0, 8'hFF, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk_vec("div0_hold_y", uo_out, 8'hFF);
            chk_vec("div0_hold_err", uio_out, 8'h80);
        end
        issue("div_9_3",  4'd9, 4'd3, 3'b101, 1'b0, 8'h03, 1'b0);
        issue("div_8_2",  4'd8, 4'd2, 3'b101, 1'b0, 8'h04, 1'b0);
        issue("rdiv_3_9", 4'd3, 4'd9, 3'b110, 1'b0, 8'h03, 1'b0);
`else
        issue("nodiv_8_2", 4'd8, 4'd2, 3'b101, 1'b0, 8'h00, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk_vec("nodiv_hold_y", uo_out, 8'h00);
            chk_vec("nodiv_hold_err", uio_out, 8'h80);
        end
        issue("nordiv_3_9", 4'd3, 4'd9, 3'b110, 1'b0, 8'h00, 1'b1);
        issue("add_clr_err", 4'd1, 4'd1, 3'b000, 1'b0, 8'h02, 1'b0);
`endif

        // Held cmd_valid with chain: acc counts 1,2,3 from a fresh reset.
        rst_n  = 1'b0;
        uio_in = 8'h00;
        @(negedge clk);
        rst_n  = 1'b1;
        ui_in  = {4'h1, 4'h5};
        uio_in = {3'b000, 1'b1, 1'b1, 3'b000};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk_vec($sformatf("held_done_%0d", i), (uio_out >> 6) & 8'h01,
                    (i % 3 == 1) ? 8'h01 : 8'h00);
            chk_vec($sformatf("held_y_%0d", i), uo_out,
                    (i < 1) ? 8'h00 : (i < 4) ? 8'h01 : (i < 7) ? 8'h02 : 8'h03);
        end
        uio_in = 8'h00;
        repeat (2) begin
            @(negedge clk);
            chk_vec("held_stop_flags", uio_out, 8'h00);
            chk_vec("held_stop_y", uo_out, 8'h03);
        end

        // Reset in EXEC aborts the command and never pulses done.
        ui_in  = {4'h4, 4'h4};
        uio_in = {3'b000, 1'b0, 1'b1, 3'b000};
        @(negedge clk);
        uio_in = 8'h00;
        rst_n  = 1'b0;
        #1;
        chk_vec("abort_uo_out", uo_out, 8'h00);
        chk_vec("abort_flags", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_vec($sformatf("abort_no_done_%0d", i), uio_out, 8'h00);
            chk_vec($sformatf("abort_y_%0d", i), uo_out, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
